// File: rtl/fp_accum_seq.sv
// Streaming IEEE-754 accumulator feeding a pipelined fp_add: rotates ADD_LAT partial
// sums through the adder to hide its latency, then folds the partials into one result.
module fp_accum_seq #(
    parameter int EXP     = 8,
    parameter int MANT    = 23,
    parameter int WIDTH   = 1 + EXP + MANT,
    parameter int ADD_LAT = 4
) (
    input  logic             clock,
    input  logic             clock_sreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             add_valid,
    output logic [WIDTH-1:0] add_dataa,
    output logic [WIDTH-1:0] add_datab,
    input  logic             add_result_valid,
    input  logic [WIDTH-1:0] add_result,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int PW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [PW-1:0] LAST_SLOT = PW'(ADD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_FOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [ADD_LAT-1:0] tag_v_q, tag_v_d;
    logic [PW-1:0]     tag_s_q [ADD_LAT];
    logic [PW-1:0]     tag_s_d [ADD_LAT];
    logic [WIDTH-1:0]  p_q [ADD_LAT];
    logic [WIDTH-1:0]  p_d [ADD_LAT];
    logic [PW-1:0]     fold_idx_q, fold_idx_d;
    logic              fold_busy_q, fold_busy_d;

    logic          can_accept;
    logic          accept;
    logic          ret_hit;
    logic [PW-1:0] ret_slot;
    logic          bypass;
    logic          fold_issue;
    logic          fold_ret;
    logic          inflight_rest;
    logic [PW-1:0] ptr_inc;

    // Reset forces in_ready low so nothing is issued while reset is held.
    assign can_accept    = ((state_q == S_IDLE) || (state_q == S_ACCUM)) && !clock_sreset;
    assign accept        = in_valid && can_accept;
    assign ret_hit       = add_result_valid && tag_v_q[ADD_LAT-1];
    assign ret_slot      = tag_s_q[ADD_LAT-1];
    assign bypass        = accept && ret_hit && (ret_slot == ptr_q);
    assign fold_issue    = (state_q == S_FOLD) && !fold_busy_q;
    assign fold_ret      = (state_q == S_FOLD) && fold_busy_q && tag_v_q[ADD_LAT-1];
    assign inflight_rest = |tag_v_q[ADD_LAT-2:0];
    assign ptr_inc       = (ptr_q == LAST_SLOT) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clock or posedge clock_sreset) begin
        if (clock_sreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = in_last ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept && in_last) begin
                    state_d = S_DRAIN;
                end
            end
            // The oldest tag retires this cycle, so only younger entries keep us draining.
            S_DRAIN: begin
                if (!inflight_rest) begin
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                if (fold_ret && (fold_idx_q == LAST_SLOT)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = can_accept;
        add_valid = 1'b0;
        add_dataa = '0;
        add_datab = '0;
        out_valid = 1'b0;
        out_data  = '0;
        if (accept) begin
            add_valid = 1'b1;
            add_dataa = in_data;
            add_datab = bypass ? add_result : p_q[ptr_q];
        end else if (fold_issue) begin
            add_valid = 1'b1;
            add_dataa = p_q[0];
            add_datab = p_q[fold_idx_q];
        end
        if (state_q == S_DONE) begin
            out_valid = 1'b1;
            out_data  = p_q[0];
        end
    end

    // Fold issues are tagged with slot 0 so their results land in P[0] via the normal write-back.
    always_comb begin
        ptr_d       = ptr_q;
        tag_v_d     = {tag_v_q[ADD_LAT-2:0], (accept || fold_issue)};
        tag_s_d[0]  = accept ? ptr_q : '0;
        for (int i = 1; i < ADD_LAT; i++) begin
            tag_s_d[i] = tag_s_q[i-1];
        end
        p_d         = p_q;
        fold_idx_d  = fold_idx_q;
        fold_busy_d = fold_busy_q;

        if (ret_hit && !bypass) begin
            p_d[ret_slot] = add_result;
        end
        if (accept || (state_q == S_ACCUM)) begin
            ptr_d = ptr_inc;
        end

        case (state_q)
            S_DRAIN: begin
                fold_idx_d  = PW'(1);
                fold_busy_d = 1'b0;
            end
            S_FOLD: begin
                if (fold_issue) begin
                    fold_busy_d = 1'b1;
                end
                if (fold_ret) begin
                    fold_busy_d = 1'b0;
                    if (fold_idx_q != LAST_SLOT) begin
                        fold_idx_d = fold_idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                for (int i = 0; i < ADD_LAT; i++) begin
                    p_d[i] = '0;
                end
                ptr_d = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or posedge clock_sreset) begin
        if (clock_sreset) begin
            ptr_q       <= '0;
            tag_v_q     <= '0;
            fold_idx_q  <= PW'(1);
            fold_busy_q <= 1'b0;
            for (int i = 0; i < ADD_LAT; i++) begin
                tag_s_q[i] <= '0;
                p_q[i]     <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            tag_v_q     <= tag_v_d;
            fold_idx_q  <= fold_idx_d;
            fold_busy_q <= fold_busy_d;
            for (int i = 0; i < ADD_LAT; i++) begin
                tag_s_q[i] <= tag_s_d[i];
                p_q[i]     <= p_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq: a latency-L adder model in the environment and a
// stream-level reference (real-valued running sum plus handshake timing) in the monitor.
module tb_fp_accum_seq;

    localparam int L = 4;

    logic        clock = 1'b0;
    logic        clock_sreset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        add_valid;
    logic [31:0] add_dataa;
    logic [31:0] add_datab;
    logic        add_result_valid;
    logic [31:0] add_result;
    logic        out_valid;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        pipe_v [L];
    logic [31:0] pipe_d [L];
    logic        stray_v = 1'b0;

    real acc_sum = 0.0;
    int  last_cyc = -1;
    int  busy_until = -1;
    int  n_words = 0;
    int  issue_cnt = 0;

    fp_accum_seq dut (
        .clock            (clock),
        .clock_sreset     (clock_sreset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_last          (in_last),
        .add_valid        (add_valid),
        .add_dataa        (add_dataa),
        .add_datab        (add_datab),
        .add_result_valid (add_result_valid),
        .add_result       (add_result),
        .out_valid        (out_valid),
        .out_data         (out_data)
    );

    always #5 clock = ~clock;

    // Single-precision <-> real conversion for the exactly representable values used here.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Environment adder: fixed latency, never reset, so in-flight results survive a DUT reset.
    initial begin
        for (int i = 0; i < L; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = 32'h0;
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        pipe_v[0] <= add_valid;
        pipe_d[0] <= fadd(add_dataa, add_datab);
        for (int i = 1; i < L; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign add_result_valid = pipe_v[L-1] | stray_v;
    assign add_result       = stray_v ? 32'h7f7f0000 : pipe_d[L-1];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Stream-level reference: sum of accepted words, result L*(L+1) cycles after the last,
    // fold issues every L+1 cycles starting L+1 after the last accept.
    logic stream_busy;
    logic exp_av;
    logic dut_accept;
    int   k;

    always @(negedge clock) begin
        if (clock_sreset) begin
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_add_valid", add_valid, 0);
            checkOutput("rst_add_dataa", add_dataa, 0);
            checkOutput("rst_add_datab", add_datab, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_out_data", out_data, 0);
            acc_sum    = 0.0;
            last_cyc   = -1;
            busy_until = -1;
            n_words    = 0;
            issue_cnt  = 0;
        end else begin
            stream_busy = (busy_until >= 0) && (cyc > last_cyc);
            dut_accept  = in_valid && in_ready;
            checkOutput("in_ready", in_ready, !stream_busy);

            exp_av = dut_accept;
            if (stream_busy) begin
                k = cyc - (last_cyc + L + 1);
                exp_av = (k >= 0) && (k % (L + 1) == 0) && (k / (L + 1) < L - 1);
            end
            checkOutput("add_valid", add_valid, exp_av);
            if (dut_accept) begin
                checkOutput("add_dataa", add_dataa, in_data);
            end else if (!exp_av) begin
                checkOutput("add_dataa_idle", add_dataa, 0);
            end
            if (add_valid) issue_cnt++;

            if (stream_busy && cyc == busy_until) begin
                checkOutput("out_valid", out_valid, 1);
                checkOutput("out_data", out_data, r2f(acc_sum));
                checkOutput("issue_count", issue_cnt, n_words + L - 1);
                acc_sum    = 0.0;
                last_cyc   = -1;
                busy_until = -1;
                n_words    = 0;
                issue_cnt  = 0;
            end else begin
                checkOutput("out_valid_idle", out_valid, 0);
                checkOutput("out_data_idle", out_data, 0);
            end

            if (dut_accept && !stream_busy) begin
                acc_sum += f2r(in_data);
                n_words++;
                if (in_last) begin
                    last_cyc   = cyc;
                    busy_until = cyc + (L + 1) * L;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input logic last);
        logic accepted;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        accepted = 1'b0;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clock);
            accepted = in_ready;
            @(posedge clock);
            #1;
        end
        checkOutput("accepted", accepted, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'h0;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && busy_until != -1; i++) @(posedge clock);
        #1;
        checkOutput("stream_done", busy_until == -1, 1);
    endtask

    initial begin
        clock_sreset = 1'b1;
        in_valid     = 1'b0;
        in_data      = 32'h0;
        in_last      = 1'b0;
        repeat (3) @(posedge clock);
        #3 clock_sreset = 1'b0;
        @(posedge clock);
        #1;

        $display("[TB] single word");
        applyStimulus(32'h3f800000, 1'b1);
        waitIdle();

        $display("[TB] back-to-back four words");
        applyStimulus(32'h3f800000, 1'b0);
        applyStimulus(32'h40000000, 1'b0);
        applyStimulus(32'h40400000, 1'b0);
        applyStimulus(32'h40800000, 1'b1);
        waitIdle();

        $display("[TB] eight words with gaps");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h3f800000, i == 7);
            if (i != 7) idleCycles(1);
        end
        waitIdle();

        $display("[TB] cancelling pair");
        applyStimulus(32'h41bef920, 1'b0);
        applyStimulus(32'hc1bef920, 1'b1);
        waitIdle();

        $display("[TB] stray results while idle");
        stray_v = 1'b1;
        repeat (3) @(posedge clock);
        #1 stray_v = 1'b0;
        idleCycles(1);

        $display("[TB] in_valid held through drain and fold");
        applyStimulus(32'h3f800000, 1'b1);
        applyStimulus(32'h40000000, 1'b1);
        waitIdle();

        $display("[TB] reset mid-stream");
        applyStimulus(32'h40a00000, 1'b0);
        applyStimulus(32'h40c00000, 1'b0);
        #2 clock_sreset = 1'b1;
        @(posedge clock);
        #3 clock_sreset = 1'b0;
        idleCycles(6);
        applyStimulus(32'h3f000000, 1'b0);
        applyStimulus(32'h3f000000, 1'b1);
        waitIdle();

        $display("[TB] random streams");
        for (int s = 0; s < 6; s++) begin
            int len;
            len = int'($urandom_range(1, 9));
            for (int w = 0; w < len; w++) begin
                int n;
                n = int'($urandom_range(0, 32)) - 16;
                applyStimulus(r2f(real'(n)), w == len - 1);
                if (w != len - 1 && $urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 2)));
            end
            waitIdle();
        end

        idleCycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Streaming floating-point accumulator that sits directly upstream of the pipelined fp_add and drives its data_valid/dataa/datab inputs.
- Sums a variable-length stream of IEEE-754 values, delimited by a last flag, into one result.
- Hides adder latency by rotating ADD_LAT partial sums through fp_add, then folds the partials into a single sum.
- Used for neuron/dot-product reductions in the inference datapath.

Parameters:
- EXP, 8, exponent width
- MANT, 23, mantissa width
- WIDTH, 1+EXP+MANT, word width
- ADD_LAT, 4, fixed fp_add latency in cycles from data_valid to result_valid; must be >= 2

Ports:
- clock  in  1  system clock
- clock_sreset  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input this cycle
- in_data  in  WIDTH  operand to accumulate
- in_last  in  1  marks final word of stream; qualified by in_valid&in_ready
- add_valid  out  1  to fp_add data_valid
- add_dataa  out  WIDTH  to fp_add dataa
- add_datab  out  WIDTH  to fp_add datab
- add_result_valid  in  1  from fp_add result_valid
- add_result  in  WIDTH  from fp_add result
- out_valid  out  1  one-cycle pulse, sum available
- out_data  out  WIDTH  stream sum, valid with out_valid

Behaviour:
- Reset (async): state=IDLE; all outputs 0; partials P[0..ADD_LAT-1]=32'h0; slot pointer and tag pipe cleared. In-flight adder results after reset are ignored because the tag pipe is empty.
- Accept condition: in_valid & in_ready.
- States: IDLE, ACCUM, DRAIN, FOLD, DONE.
- IDLE:
  - in_ready=1.
  - Accept -> ACCUM, or DRAIN if in_last.
  - The accepted word is issued exactly as in ACCUM.
- ACCUM:
  - in_ready=1; no backpressure.
  - ptr increments mod ADD_LAT every cycle, whether or not a word is accepted.
  - On accept: add_valid=1, add_dataa=in_data, add_datab=B, where B=add_result if a tagged result for slot ptr returns this cycle (bypass), else P[ptr].
  - Tag pipe (ADD_LAT deep, valid+slot) records ptr.
  - When add_result_valid arrives with a valid tag, P[tag] <= add_result, unless consumed by bypass that same cycle; in that case the new issue supersedes it.
  - Accept with in_last -> DRAIN.
- DRAIN:
  - in_ready=0; no issues.
  - Write back returning results.
  - -> FOLD when tag pipe is empty.
- FOLD:
  - Serial fold into P[0]: for i=1..ADD_LAT-1, issue add(P[0],P[i]), wait ADD_LAT cycles for the result, write P[0], issue the next on the following cycle.
  - After the final result is written -> DONE.
- DONE:
  - out_valid=1 and out_data=P[0] for exactly one cycle.
  - Clear all P to 0 and ptr to 0 -> IDLE.
  - out_valid and out_data are 0 in every other state.
- Issue outputs: add_valid=0 and add_dataa/add_datab=0 on all non-issue cycles.
- Latency: last word accepted at cycle T gives out_valid at T+(ADD_LAT+1)*ADD_LAT (T+20 for ADD_LAT=4).
- in_ready is low from T+1 through the out_valid cycle; it returns high the cycle after out_valid.
- Stray add_result_valid with an empty tag is ignored, with no state change.
- in_last in a single-word stream: the word is issued against P=0 and the fold adds zeros; the result equals the input (fp_add x+0=x).
- Reset mid-stream (any state): immediate return to IDLE; the partial sum is discarded; no out_valid.

Test Plan:
1. Single word 3f800000 with in_last in IDLE -> out_valid exactly 20 cycles later, out_data=3f800000.
2. Back-to-back 3f800000, 40000000, 40400000, 40800000 (last on the fourth) -> out_data=41200000 (10.0); add_valid high on 4 consecutive cycles, then 3 fold issues spaced 5 cycles apart.
3. Eight 3f800000 words with in_valid toggling every cycle (gaps) -> out_data=41000000 (8.0); exercises ptr rotation and result bypass.
4. Stream 41bef920, c1bef920 (last) -> out_data=00000000.
5. in_valid held high through DRAIN/FOLD -> no accepts while in_ready=0. A second stream 40000000 (last) after DONE -> out_data=40000000, proving partials were cleared.
6. Reset pulse two words into a stream, stray results arriving afterward -> all outputs 0, no out_valid; subsequent stream 3f000000, 3f000000 (last) -> out_data=3f800000.
